// File: rtl/instr_fetch.sv
// Instruction fetch: one imem read in flight, words queued in a flushable prefetch FIFO; 1-cycle ack-to-valid.
// Requests stall while FIFO occupancy plus in-flight read reaches DEPTH; the CPU throttles the drain with instr_ready.

module fifo #(
   parameter int W     = 64,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_dat,
   input  logic                     pop,
   output logic [W-1:0]             head_dat,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push && !flush)
         mem[wr_ptr] <= push_dat;
   end

   // Caller guarantees push only with space and pop only when non-empty.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   assign head_dat = mem[rd_ptr];
endmodule

module instr_fetch #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                    clk,
   input  logic                    reset_n,
   output logic                    imem_req,
   output logic [31:0]             imem_addr,
   input  logic                    imem_ack,
   input  logic [31:0]             imem_data,
   output logic [31:0]             instruction,
   output logic [31:0]             instr_pc,
   output logic                    instr_valid,
   input  logic                    instr_ready,
   input  logic                    redirect,
   input  logic [31:0]             redirect_pc,
   output logic [$clog2(DEPTH):0]  fifo_count
);
   localparam int             CW      = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   typedef enum logic {IDLE, REQ} state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] word;
   } fetch_ent_t;

   state_t      state;
   logic [31:0] fetch_pc;
   logic [31:0] fetch_pc_nxt;
   logic        discard;
   logic        ack_fire;
   logic        push;
   logic        pop;
   logic [CW-1:0] count_nxt;
   fetch_ent_t  push_ent;
   fetch_ent_t  head_ent;
   logic        unused_rpc_lsb;

   assign unused_rpc_lsb = ^redirect_pc[1:0];

   // Redirect wins over both push and pop in the same cycle.
   assign ack_fire    = (state == REQ) && imem_ack;
   assign push        = ack_fire && !discard && !redirect;
   assign instr_valid = (fifo_count != '0);
   assign pop         = instr_valid && instr_ready && !redirect;
   assign count_nxt   = redirect ? '0 : fifo_count + CW'(push) - CW'(pop);
   assign push_ent    = '{pc: imem_addr, word: imem_data};

   always_comb begin
      fetch_pc_nxt = fetch_pc;
      if (redirect)
         fetch_pc_nxt = {redirect_pc[31:2], 2'b00};
      else if (push)
         fetch_pc_nxt = fetch_pc + 32'd4;
   end

   fifo #(.W($bits(fetch_ent_t)), .DEPTH(DEPTH)) u_fifo (
      .clk      (clk),
      .reset_n  (reset_n),
      .flush    (redirect),
      .push     (push),
      .push_dat (push_ent),
      .pop      (pop),
      .head_dat (head_ent),
      .count    (fifo_count)
   );

   // A started read is never aborted; a redirect under it only marks the reply for dropping.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         imem_req  <= 1'b0;
         imem_addr <= RESET_PC;
         fetch_pc  <= RESET_PC;
         discard   <= 1'b0;
      end else begin
         fetch_pc <= fetch_pc_nxt;
         case (state)
            IDLE: begin
               if (count_nxt < DEPTH_C) begin
                  state     <= REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= fetch_pc_nxt;
               end
            end
            REQ: begin
               if (imem_ack) begin
                  discard <= 1'b0;
                  if (count_nxt < DEPTH_C) begin
                     imem_addr <= fetch_pc_nxt;
                  end else begin
                     state    <= IDLE;
                     imem_req <= 1'b0;
                  end
               end else if (redirect) begin
                  discard <= 1'b1;
               end
            end
         endcase
      end
   end

   assign instruction = instr_valid ? head_ent.word : 32'h0;
   assign instr_pc    = instr_valid ? head_ent.pc   : 32'h0;
endmodule
